// File: rtl/crc_frame_checker.sv
// crc_frame_checker: streams CRC_WIDTH-bit words, recomputes the CRC and reports pass/fail, length and both CRCs on a held result handshake
module crc_frame_checker #(
  parameter int CRC_WIDTH = 8,
  parameter int LENW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CRC_WIDTH-1:0] genPoly,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [CRC_WIDTH-1:0] inData,
  input  logic                 inLast,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 crcOk,
  output logic                 lenErr,
  output logic [CRC_WIDTH-1:0] crcCalc,
  output logic [CRC_WIDTH-1:0] crcRx,
  output logic [LENW-1:0]      dataLen
);
  typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;
  state_t state;
  logic [CRC_WIDTH-1:0] crcReg, polyReg, stepCrc;
  logic [LENW-1:0] lenCnt;
  logic beat;
  function automatic logic [CRC_WIDTH-1:0] crcStep(input logic [CRC_WIDTH-1:0] c, d, p);
    logic [CRC_WIDTH-1:0] t;
    t = c ^ d;
    for (int i = 0; i < CRC_WIDTH; i++) t = t[CRC_WIDTH-1] ? (t << 1) ^ p : t << 1;
    return t;
  endfunction
  assign inReady = state != RESULT;
  assign outValid = state == RESULT;
  assign beat = inValid && inReady;
  assign stepCrc = state == IDLE ? crcStep('0, inData, genPoly) : crcStep(crcReg, inData, polyReg);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      crcOk <= 1'b0;
      lenErr <= 1'b0;
      crcCalc <= '0;
      crcRx <= '0;
      dataLen <= '0;
      crcReg <= '0;
      polyReg <= '0;
      lenCnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (beat) begin
            if (inLast) begin
              crcCalc <= '0;
              crcRx <= inData;
              dataLen <= '0;
              lenErr <= 1'b1;
              crcOk <= 1'b0;
              state <= RESULT;
            end else begin
              polyReg <= genPoly;
              crcReg <= stepCrc;
              lenCnt <= LENW'(1);
              state <= RUN;
            end
          end
        RUN:
          if (beat) begin
            if (inLast) begin
              crcCalc <= crcReg;
              crcRx <= inData;
              dataLen <= lenCnt;
              lenErr <= 1'b0;
              crcOk <= crcReg == inData;
              state <= RESULT;
            end else begin
              crcReg <= stepCrc;
              lenCnt <= lenCnt + LENW'(lenCnt != '1);
            end
          end
        RESULT: if (outReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_frame_checker.sv
// tb_crc_frame_checker: directed self-checking bench for crc_frame_checker
module tb_crc_frame_checker;
  logic clk = 0, rst = 1;
  logic [7:0] genPoly = 8'h07, inData = 0;
  logic inValid = 0, inLast = 0, outReady = 1;
  logic inReady, outValid, crcOk, lenErr;
  logic [7:0] crcCalc, crcRx;
  logic [15:0] dataLen;
  int nChecks = 0, nFail = 0;
  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  crc_frame_checker #(.CRC_WIDTH(8), .LENW(16)) dut (
    .clk(clk), .rst(rst), .genPoly(genPoly), .inValid(inValid), .inReady(inReady),
    .inData(inData), .inLast(inLast), .outValid(outValid), .outReady(outReady),
    .crcOk(crcOk), .lenErr(lenErr), .crcCalc(crcCalc), .crcRx(crcRx), .dataLen(dataLen)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic [7:0] d, input logic l);
    inValid = 1;
    inData = d;
    inLast = l;
    @(posedge clk);
    #1;
  endtask

  task automatic sendMsg(input int n, input logic [7:0] crc);
    for (int i = 0; i < n; i++) beat(msg[i], 0);
    beat(crc, 1);
    inValid = 0;
    inLast = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nChecks++; if (inReady !== 1'b1) begin nFail++; $display("FAIL reset_inReady got %b want 1", inReady); end
    nChecks++; if (outValid !== 1'b0) begin nFail++; $display("FAIL reset_outValid got %b want 0", outValid); end
    nChecks++; if ({crcOk, lenErr} !== 2'b00) begin nFail++; $display("FAIL reset_flags got %b want 00", {crcOk, lenErr}); end
    nChecks++; if ({crcCalc, crcRx, dataLen} !== 32'h0) begin nFail++; $display("FAIL reset_values got %h want 0", {crcCalc, crcRx, dataLen}); end
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    outReady = 1;
    sendMsg(9, 8'hF4);
    @(negedge clk);
    nChecks++; if (outValid !== 1'b1) begin nFail++; $display("FAIL good_outValid got %b want 1", outValid); end
    nChecks++; if (crcOk !== 1'b1) begin nFail++; $display("FAIL good_crcOk got %b want 1", crcOk); end
    nChecks++; if (crcCalc !== 8'hF4) begin nFail++; $display("FAIL good_crcCalc got %h want f4", crcCalc); end
    nChecks++; if (crcRx !== 8'hF4) begin nFail++; $display("FAIL good_crcRx got %h want f4", crcRx); end
    nChecks++; if (dataLen !== 16'd9) begin nFail++; $display("FAIL good_dataLen got %0d want 9", dataLen); end
    nChecks++; if (lenErr !== 1'b0) begin nFail++; $display("FAIL good_lenErr got %b want 0", lenErr); end
    @(posedge clk);
    #1;
    nChecks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin nFail++; $display("FAIL good_release got outValid=%b inReady=%b want 0 1", outValid, inReady); end
  endtask

  task automatic test_bad_crc();
    sendMsg(9, 8'hF5);
    @(negedge clk);
    nChecks++; if (outValid !== 1'b1 || crcOk !== 1'b0) begin nFail++; $display("FAIL bad_crcOk got valid=%b ok=%b want 1 0", outValid, crcOk); end
    nChecks++; if (crcCalc !== 8'hF4 || crcRx !== 8'hF5) begin nFail++; $display("FAIL bad_crcs got calc=%h rx=%h want f4 f5", crcCalc, crcRx); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gaps();
    beat(8'h01, 0);
    inValid = 0;
    inData = 8'hFF;
    inLast = 1;
    @(posedge clk);
    #1;
    nChecks++; if (outValid !== 1'b0) begin nFail++; $display("FAIL gap_accepted got outValid=%b want 0", outValid); end
    beat(8'h07, 1);
    inValid = 0;
    inLast = 0;
    @(negedge clk);
    nChecks++; if (outValid !== 1'b1 || crcOk !== 1'b1) begin nFail++; $display("FAIL gap_crcOk got valid=%b ok=%b want 1 1", outValid, crcOk); end
    nChecks++; if (dataLen !== 16'd1 || crcCalc !== 8'h07) begin nFail++; $display("FAIL gap_len got len=%0d calc=%h want 1 07", dataLen, crcCalc); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_len_err();
    sendMsg(0, 8'h00);
    @(negedge clk);
    nChecks++; if (outValid !== 1'b1 || lenErr !== 1'b1 || crcOk !== 1'b0) begin nFail++; $display("FAIL lenerr_flags got valid=%b lenErr=%b ok=%b want 1 1 0", outValid, lenErr, crcOk); end
    nChecks++; if (dataLen !== 16'd0 || crcCalc !== 8'h00) begin nFail++; $display("FAIL lenerr_values got len=%0d calc=%h want 0 00", dataLen, crcCalc); end
    @(posedge clk);
    #1;
    sendMsg(9, 8'hF4);
    @(negedge clk);
    nChecks++; if (crcOk !== 1'b1 || lenErr !== 1'b0 || dataLen !== 16'd9) begin nFail++; $display("FAIL lenerr_next got ok=%b lenErr=%b len=%0d want 1 0 9", crcOk, lenErr, dataLen); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    outReady = 0;
    sendMsg(9, 8'hF4);
    inValid = 1;
    inData = msg[0];
    inLast = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nChecks++; if (outValid !== 1'b1 || inReady !== 1'b0) begin nFail++; $display("FAIL hold_hs%0d got valid=%b ready=%b want 1 0", i, outValid, inReady); end
      nChecks++; if (crcOk !== 1'b1 || crcCalc !== 8'hF4 || dataLen !== 16'd9) begin nFail++; $display("FAIL hold_res%0d got ok=%b calc=%h len=%0d want 1 f4 9", i, crcOk, crcCalc, dataLen); end
      @(posedge clk);
      #1;
    end
    outReady = 1;
    @(negedge clk);
    nChecks++; if (inReady !== 1'b0) begin nFail++; $display("FAIL handshake_inReady got %b want 0", inReady); end
    @(posedge clk);
    #1;
    nChecks++; if (inReady !== 1'b1 || outValid !== 1'b0) begin nFail++; $display("FAIL after_hs got ready=%b valid=%b want 1 0", inReady, outValid); end
    for (int i = 0; i < 9; i++) beat(msg[i], 0);
    beat(8'hF4, 1);
    inValid = 0;
    inLast = 0;
    @(negedge clk);
    nChecks++; if (crcOk !== 1'b1 || dataLen !== 16'd9) begin nFail++; $display("FAIL b2b_next got ok=%b len=%0d want 1 9", crcOk, dataLen); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 4; i++) beat(msg[i], 0);
    inValid = 0;
    rst = 1;
    #1;
    nChecks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin nFail++; $display("FAIL rst_hs got valid=%b ready=%b want 0 1", outValid, inReady); end
    nChecks++; if ({crcOk, lenErr, crcCalc, crcRx, dataLen} !== 34'h0) begin nFail++; $display("FAIL rst_values got %h want 0", {crcOk, lenErr, crcCalc, crcRx, dataLen}); end
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      nChecks++; if (outValid !== 1'b0) begin nFail++; $display("FAIL rst_spurious%0d got %b want 0", i, outValid); end
    end
    sendMsg(9, 8'hF4);
    @(negedge clk);
    nChecks++; if (outValid !== 1'b1 || crcOk !== 1'b1 || dataLen !== 16'd9) begin nFail++; $display("FAIL rst_next got valid=%b ok=%b len=%0d want 1 1 9", outValid, crcOk, dataLen); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_gaps();
    test_len_err();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/crc_frame_checker.md
# crc_frame_checker

Receive-side counterpart of the team's parallel CRC generator. It accepts a frame as a stream of CRC_WIDTH-bit words over a valid/ready handshake, where the final word carries the transmitted CRC. It recomputes the CRC over the data words one word per cycle, using the generator's algorithm: MSB-first, init all-zero, no reflection, no final XOR, polynomial given without its leading 1. It then reports pass/fail, length and both CRC values on a held result handshake. It sits between a link receiver and the frame consumer.

## Interface
- CRC_WIDTH, 8, CRC width; also the width of every input word.
- LENW, 16, width of the data-word length counter.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- genPoly  in  CRC_WIDTH  generator polynomial without its x^CRC_WIDTH term; sampled on the first accepted beat of each frame
- inValid  in  1  input word valid
- inReady  out  1  checker can accept a word
- inData  in  CRC_WIDTH  frame word, MSB = first bit on the wire
- inLast  in  1  this word is the received CRC and closes the frame
- outValid  out  1  result valid, held until accepted
- outReady  in  1  consumer accepts result
- crcOk  out  1  1 = computed CRC equals received CRC and lenErr=0
- lenErr  out  1  frame had no data words (inLast on first beat)
- crcCalc  out  CRC_WIDTH  CRC computed over the data words
- crcRx  out  CRC_WIDTH  received CRC word
- dataLen  out  LENW  number of data words, saturating

## Operation
- Beat accepted = inValid && inReady. inReady = 1 in IDLE and RUN, 0 in RESULT.
- FSM states:
  - IDLE (reset state).
  - RUN.
  - RESULT.
- IDLE, accepted beat with inLast=0: latch genPoly into polyReg. Load crcReg with f(0, inData). Set lenCnt = 1. Go to RUN.
- IDLE, accepted beat with inLast=1: crcCalc=0, crcRx=inData, dataLen=0, lenErr=1, crcOk=0. Go to RESULT.
- RUN, accepted beat with inLast=0: crcReg <= f(crcReg, inData). lenCnt <= lenCnt+1, saturating at 2^LENW-1.
- RUN, accepted beat with inLast=1: crcCalc <= crcReg, crcRx <= inData, dataLen <= lenCnt, lenErr <= 0, crcOk <= (crcReg == inData). Go to RESULT.
- RESULT: outValid=1 and result registers are stable. When outValid && outReady, go to IDLE.
- No accepted beat in IDLE or RUN: state and registers hold. Gaps in inValid are legal.
- CRC step f(c, d):
  - Form t = c ^ d.
  - Perform CRC_WIDTH serial steps on {t, CRC_WIDTH zeros}: if msb=1, shift left and XOR polyReg; otherwise shift left only.
  - Implemented as an unrolled combinational chain, one word per cycle.
- Changes to genPoly mid-frame have no effect until the next frame's first beat.
- Comparing crcReg with the CRC word is equivalent to a zero residue, and is the required implementation.

## Timing
- Reset values:
  - state=IDLE, inReady=1, outValid=0.
  - crcOk=0, lenErr=0, crcCalc=0, crcRx=0, dataLen=0.
  - crcReg=0, polyReg=0, lenCnt=0.
- Throughput: one word per clk in IDLE/RUN, with no bubbles between beats of a frame.
- Latency: outValid rises on the clk edge that accepts the inLast beat, i.e. it is visible the next cycle.
- Result outputs change only on that edge and hold until the handshake.
- Output is a handshake, not a pulse: outValid stays 1 while outReady=0.
- In the handshake cycle, inReady=0, so the next frame's first beat can be accepted at the earliest one cycle after the outValid && outReady cycle.
- rst asserted mid-frame or during RESULT: return to the reset values immediately. The partial frame is discarded and no result is produced.

## Test plan
- CRC_WIDTH=8, genPoly=0x07, data 0x31..0x39 ("123456789") then inLast word 0xF4, outReady=1 → one cycle after the last beat: outValid=1, crcOk=1, crcCalc=0xF4, crcRx=0xF4, dataLen=9, lenErr=0.
- Same frame with the CRC word 0xF5 → crcOk=0, crcCalc=0xF4, crcRx=0xF5.
- genPoly=0x07, data 0x01, CRC 0x07; inValid toggled 1/0 every cycle → crcOk=1, dataLen=1. Also check no beat is accepted while inValid=0.
- First beat has inLast=1 with word 0x00 → lenErr=1, crcOk=0, dataLen=0; next frame is processed normally.
- outReady held 0 for 5 cycles after the result while inValid=1 with the next frame → outValid and results stable and inReady=0 for those 5 cycles. The first beat of the next frame is accepted one cycle after the handshake.
- rst pulsed after 4 data words of a frame, then a full "123456789"/0xF4 frame is sent → all outputs at reset values during rst, no spurious outValid, and the second frame reports crcOk=1, dataLen=9.
